// File: rtl/forwarding_scoreboard.sv
// Tracks in-flight register writers and picks per-source forwarding stages; load-use stall and selects are zero-latency combinational.
// advance=0 holds all entries; optional load-use stall counter is enabled with FWD_SCOREBOARD_PERF_EN.
module forwarding_scoreboard #(
    parameter int  REG_W   = 3,
    parameter int  NUM_SRC = 2,
    parameter int  DEPTH   = 3,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic                       id_regwrite,
    input  logic [REG_W-1:0]           id_dest,
    input  logic                       id_is_load,
    input  logic [NUM_SRC*REG_W-1:0]   src_num,
    input  logic [NUM_SRC-1:0]         src_en,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       load_use_stall,
    output logic [15:0]                stall_count
);

    logic [DEPTH:1]            wr_valid_q, wr_valid_d;
    logic [DEPTH:1]            is_load_q,  is_load_d;
    logic [DEPTH:1][REG_W-1:0] dest_q,     dest_d;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        fwd_sel        = '0;
        load_use_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (src_en[i] && wr_valid_q[k] && (dest_q[k] == src_num[i*REG_W +: REG_W]))
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
            if (src_en[i] && wr_valid_q[1] && is_load_q[1] &&
                (dest_q[1] == src_num[i*REG_W +: REG_W]))
                load_use_stall = 1'b1;
        end
    end

    always_comb begin
        wr_valid_d = wr_valid_q;
        is_load_d  = is_load_q;
        dest_d     = dest_q;
        if (advance) begin
            for (int k = 2; k <= DEPTH; k++) begin
                wr_valid_d[k] = wr_valid_q[k-1];
                is_load_d[k]  = is_load_q[k-1];
                dest_d[k]     = dest_q[k-1];
            end
            if (flush || load_use_stall) begin
                wr_valid_d[1] = 1'b0;
                is_load_d[1]  = 1'b0;
                dest_d[1]     = '0;
            end else begin
                wr_valid_d[1] = id_valid & id_regwrite;
                is_load_d[1]  = id_is_load;
                dest_d[1]     = id_dest;
            end
        end else if (flush) begin
            wr_valid_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_q <= '0;
            is_load_q  <= '0;
            dest_q     <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            is_load_q  <= is_load_d;
            dest_q     <= dest_d;
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (advance && load_use_stall && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count_q <= 16'h0000;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Randomised plus directed bench for forwarding_scoreboard with a queue-based reference pipeline and decoupled monitor.
module tb_forwarding_scoreboard;

    localparam int REG_W = 3, NUM_SRC = 2, DEPTH = 3, SEL_W = 2;

    logic                     clk = 1'b0;
    logic                     rst, advance, flush, id_valid, id_regwrite, id_is_load;
    logic [REG_W-1:0]         id_dest;
    logic [NUM_SRC*REG_W-1:0] src_num;
    logic [NUM_SRC-1:0]       src_en;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     load_use_stall;
    logic [15:0]              stall_count;

    forwarding_scoreboard #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .advance(advance), .flush(flush),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_dest(id_dest),
        .id_is_load(id_is_load), .src_num(src_num), .src_en(src_en),
        .fwd_sel(fwd_sel), .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int dest; bit ld; } entry_t;
    typedef struct { int sel0; int sel1; bit stall; int cnt; string tag; } exp_t;

    entry_t pipe[$];      // pipe[0] is the youngest in-flight instruction (stage 1)
    int     model_cnt;
    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     rows_seen = 0;

`ifdef FWD_SCOREBOARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    function automatic int want_sel(int src, bit en);
        if (!en) return 0;
        foreach (pipe[j]) if (pipe[j].v && pipe[j].dest == src) return j + 1;
        return 0;
    endfunction

    function automatic bit want_stall(int s0, int s1, bit [1:0] en);
        if (!(pipe[0].v && pipe[0].ld)) return 1'b0;
        return (en[0] && pipe[0].dest == s0) || (en[1] && pipe[0].dest == s1);
    endfunction

    function automatic void model_reset();
        entry_t z;
        z = '{v: 1'b0, dest: 0, ld: 1'b0};
        pipe.delete();
        for (int k = 0; k < DEPTH; k++) pipe.push_back(z);
        model_cnt = 0;
    endfunction

    // One cycle: apply inputs, predict outputs from the reference pipe, then retire the clock edge in the model.
    task automatic drive(input bit a, input bit f, input bit v, input bit rw, input int d, input bit ld,
                         input int s0, input int s1, input bit [1:0] en, input bit r, input string tag);
        exp_t   e;
        entry_t n;
        bit     stl;
        rst = r; advance = a; flush = f; id_valid = v; id_regwrite = rw;
        id_dest = REG_W'(d); id_is_load = ld;
        src_num = {REG_W'(s1), REG_W'(s0)}; src_en = en;
        stl = want_stall(s0, s1, en);
        e.sel0 = want_sel(s0, en[0]); e.sel1 = want_sel(s1, en[1]);
        e.stall = stl; e.cnt = PERF ? model_cnt : 0; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) model_reset();
        else if (a) begin
            n = '{v: (!f && !stl) ? (v & rw) : 1'b0, dest: d, ld: ld};
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (stl && model_cnt < 65535) model_cnt++;
        end else if (f) pipe[0].v = 1'b0;
        #1;
    endtask

    task automatic idle(input int s0, input int s1, input bit [1:0] en, input string tag);
        drive(1, 0, 0, 0, 0, 0, s0, s1, en, 0, tag);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rows_seen++;
            n_checks++;
            if (fwd_sel[1:0] !== SEL_W'(e.sel0)) begin
                n_fail++;
                $display("FAIL %s fwd_sel0 got %0d want %0d @%0t", e.tag, fwd_sel[1:0], e.sel0, $time);
            end
            n_checks++;
            if (fwd_sel[3:2] !== SEL_W'(e.sel1)) begin
                n_fail++;
                $display("FAIL %s fwd_sel1 got %0d want %0d @%0t", e.tag, fwd_sel[3:2], e.sel1, $time);
            end
            n_checks++;
            if (load_use_stall !== e.stall) begin
                n_fail++;
                $display("FAIL %s stall got %0b want %0b @%0t", e.tag, load_use_stall, e.stall, $time);
            end
            n_checks++;
            if (stall_count !== 16'(e.cnt)) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d @%0t", e.tag, stall_count, e.cnt, $time);
            end
        end
    end

    initial begin
        model_reset();
        rst = 1; advance = 0; flush = 0; id_valid = 0; id_regwrite = 0;
        id_dest = '0; id_is_load = 0; src_num = '0; src_en = '0;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 1, 2, 2'b11, 0, "reset_state");

        // back-to-back ALU
        drive(1, 0, 1, 1, 3, 0, 0, 0, 2'b00, 0, "add_r3");
        drive(1, 0, 0, 0, 0, 0, 3, 0, 2'b01, 0, "alu_fwd");

        // load-use: stall one advancing cycle, then forward from stage 2
        drive(1, 0, 1, 1, 2, 1, 0, 0, 2'b00, 0, "ldr_r2");
        drive(1, 0, 1, 1, 4, 0, 0, 2, 2'b10, 0, "load_use");
        drive(1, 0, 1, 1, 4, 0, 0, 2, 2'b10, 0, "load_fwd2");

        // priority with R5 in stages 1 and 3
        drive(1, 0, 1, 1, 5, 0, 0, 0, 2'b00, 0, "r5_a");
        drive(1, 0, 1, 1, 6, 0, 0, 0, 2'b00, 0, "r6");
        drive(1, 0, 1, 1, 5, 0, 0, 0, 2'b00, 0, "r5_b");
        drive(0, 0, 0, 0, 0, 0, 5, 6, 2'b11, 0, "prio_en");
        drive(0, 0, 0, 0, 0, 0, 5, 6, 2'b10, 0, "prio_dis");

        // hold for three cycles, then flush a would-be load-use
        drive(1, 0, 1, 1, 1, 1, 0, 0, 2'b00, 0, "ld_r1");
        for (int c = 0; c < 3; c++) drive(0, 0, 1, 1, 7, 0, 1, 6, 2'b11, 0, "hold");
        drive(1, 1, 1, 1, 7, 0, 1, 6, 2'b11, 0, "flush_adv");
        drive(0, 0, 0, 0, 0, 0, 1, 6, 2'b11, 0, "after_flush");
        drive(0, 1, 0, 0, 0, 0, 6, 1, 2'b11, 0, "flush_hold");
        drive(0, 0, 0, 0, 0, 0, 6, 1, 2'b11, 0, "after_flush_hold");

        // aging through all stages, R0 as an ordinary register
        drive(1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, "issue_r0");
        for (int c = 0; c < 4; c++) idle(0, 0, 2'b11, "aging");

        // reset with every stage valid
        for (int c = 0; c < 3; c++) drive(1, 0, 1, 1, c + 1, 0, 0, 0, 2'b00, 0, "fill");
        drive(1, 0, 1, 1, 4, 1, 1, 2, 2'b11, 1, "rst_mid");
        drive(1, 0, 1, 1, 4, 1, 1, 2, 2'b11, 0, "post_rst");

        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 60) == 0, "random");
        end

`ifdef FWD_SCOREBOARD_PERF_EN
        drive(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, "perf_rst");
        for (int c = 0; c < 70000; c++) begin
            drive(1, 0, 1, 1, 2, 1, 0, 0, 2'b00, 0, "perf_ld");
            drive(1, 0, 0, 0, 0, 0, 2, 0, 2'b01, 0, "perf_stall");
        end
        idle(0, 0, 2'b00, "perf_sat");
`endif

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || rows_seen == 0) begin
            n_fail++;
            $display("FAIL drain pending %0d rows_seen %0d", exp_q.size(), rows_seen);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
